axil_sram_slave: RTL



---
 rtl/axil_sram_pkg.sv | 18 +
 rtl/axil_sram_slave.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axil_sram_pkg.sv
// Shared types for the AXI4-Lite to 16-bit SRAM bridge.
// Response codes and controller states.
package axil_sram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA
    } state_t;

endpackage

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave turning single-beat accesses into 16-bit SRAM word cycles.
// Optional AXIL_SRAM_RANGE_CHECK_EN rejects addresses above the SRAM with SLVERR.
module axil_sram_slave
    import axil_sram_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 20,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEMORY_ADDR_WIDTH  = 18,
    parameter int MEMORY_DATA_WIDTH  = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTB,
    input  logic                            S_AXI_WAVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [MEMORY_ADDR_WIDTH-1:0]    SRAM_address,
    output logic [MEMORY_DATA_WIDTH-1:0]    SRAM_write_data,
    input  logic [MEMORY_DATA_WIDTH-1:0]    SRAM_read_data,
    output logic                            SRAM_we_n,
    output logic [1:0]                      SRAM_be_n
);

    localparam int MAW = MEMORY_ADDR_WIDTH;

    state_t state;
    state_t state_nxt;
    logic   last_write;
    logic   wr_en;
    logic   err;
    logic   wr_req;
    logic   rd_req;
    logic   grant_wr;
    logic   grant_rd;
    logic   aw_oor;
    logic   ar_oor;
    logic   unused;

`ifdef AXIL_SRAM_RANGE_CHECK_EN
    assign aw_oor = |(S_AXI_AWADDR >> (MAW + 2));
    assign ar_oor = |(S_AXI_ARADDR >> (MAW + 2));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    assign unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTB};

    // A write only wins back-to-back contention if the last grant was a read
    assign wr_req   = S_AXI_AWVALID & S_AXI_WAVALID;
    assign rd_req   = S_AXI_ARVALID;
    assign grant_wr = (state == S_IDLE) & wr_req & (~rd_req | ~last_write);
    assign grant_rd = (state == S_IDLE) & rd_req & ~grant_wr;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (grant_wr) begin
                    state_nxt = S_WRITE;
                end else if (grant_rd) begin
                    state_nxt = S_READ;
                end
            end
            S_WRITE: state_nxt = S_WRESP;
            S_WRESP: begin
                if (S_AXI_BVALID && S_AXI_BREADY) begin
                    state_nxt = S_IDLE;
                end
            end
            S_READ:  state_nxt = S_RDATA;
            S_RDATA: begin
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_AWREADY   <= 1'b0;
            S_AXI_WREADY    <= 1'b0;
            S_AXI_ARREADY   <= 1'b0;
            S_AXI_BVALID    <= 1'b0;
            S_AXI_BRESP     <= OKAY;
            S_AXI_RVALID    <= 1'b0;
            S_AXI_RRESP     <= OKAY;
            S_AXI_RDATA     <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            SRAM_be_n       <= 2'b11;
            last_write      <= 1'b0;
            wr_en           <= 1'b0;
            err             <= 1'b0;
        end else begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            SRAM_we_n     <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        S_AXI_AWREADY   <= 1'b1;
                        S_AXI_WREADY    <= 1'b1;
                        SRAM_address    <= S_AXI_AWADDR[MAW+1:2];
                        SRAM_write_data <= S_AXI_WDATA[MEMORY_DATA_WIDTH-1:0];
                        SRAM_be_n       <= ~S_AXI_WSTB[1:0];
                        wr_en           <= |S_AXI_WSTB[1:0] & ~aw_oor;
                        err             <= aw_oor;
                        last_write      <= 1'b1;
                    end else if (grant_rd) begin
                        S_AXI_ARREADY <= 1'b1;
                        if (!ar_oor) begin
                            SRAM_address <= S_AXI_ARADDR[MAW+1:2];
                        end
                        err        <= ar_oor;
                        last_write <= 1'b0;
                    end
                end
                S_WRITE: SRAM_we_n <= ~wr_en;
                S_WRESP: begin
                    if (!S_AXI_BVALID) begin
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= err ? SLVERR : OKAY;
                    end else if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                    end
                end
                S_READ: ;
                S_RDATA: begin
                    if (!S_AXI_RVALID) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RRESP  <= err ? SLVERR : OKAY;
                        S_AXI_RDATA  <= err ? '0 : C_S_AXI_DATA_WIDTH'(SRAM_read_data);
                    end else if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
